// File: rtl/threefish_inv_round_group_if.sv
// Handshake bundle for the Threefish-512 inverse round group: input state channel and output state channel.
interface threefish_inv_round_group_if;
    logic [511:0] inData;
    logic         groupOdd;
    logic         inValid;
    logic         inReady;
    logic [511:0] outData;
    logic         outValid;
    logic         outReady;

    modport master (
        output inData, groupOdd, inValid, outReady,
        input  inReady, outData, outValid
    );

    modport slave (
        input  inData, groupOdd, inValid, outReady,
        output inReady, outData, outValid
    );
endinterface

// File: rtl/threefish_inv_round_group.sv
// Threefish-512 decryption: four inverse rounds (inverse Pi, then inverse MIX) per group, iterated.
// Optional THREEFISH_INV_UNROLL2_EN chains two inverse rounds per clock.
module threefish_inv_round_group #(
    parameter int WORDW   = 64,
    parameter int NROUNDS = 4
) (
    input logic                        clk,
    input logic                        rstn,
    threefish_inv_round_group_if.slave bus
);
    localparam int SW = 8 * WORDW;
`ifdef THREEFISH_INV_UNROLL2_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif
    localparam logic [1:0] LAST_CNT = 2'(NROUNDS - STAGES);

    localparam logic [5:0] RTAB [8][4] = '{
        '{6'd46, 6'd36, 6'd19, 6'd37},
        '{6'd33, 6'd27, 6'd14, 6'd42},
        '{6'd17, 6'd49, 6'd36, 6'd39},
        '{6'd44, 6'd9,  6'd54, 6'd56},
        '{6'd39, 6'd30, 6'd34, 6'd24},
        '{6'd13, 6'd50, 6'd10, 6'd17},
        '{6'd25, 6'd29, 6'd39, 6'd43},
        '{6'd8,  6'd35, 6'd56, 6'd22}
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    cnt_reg, cnt_next;
    logic          odd_reg, odd_next;
    logic [SW-1:0] data_reg, data_next;
    logic          out_valid_reg, out_valid_next;
    logic [2:0]    dm8;
    logic [SW-1:0] round_data;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [5:0] r);
        logic [127:0] t;
        t = {x, x} >> r;
        return t[63:0];
    endfunction

    function automatic logic [511:0] inv_round(input logic [511:0] s, input logic [2:0] d);
        logic [63:0]  w [8];
        logic [63:0]  p [8];
        logic [63:0]  x0, x1;
        logic [511:0] r;
        for (int i = 0; i < 8; i++) w[i] = s[511-64*i -: 64];
        p = '{w[6], w[1], w[0], w[7], w[2], w[5], w[4], w[3]};
        r = '0;
        for (int j = 0; j < 4; j++) begin
            x1 = rotr64(p[2*j+1] ^ p[2*j], RTAB[d][j]);
            x0 = p[2*j] - x1;
            r[511-128*j -: 64] = x0;
            r[447-128*j -: 64] = x1;
        end
        return r;
    endfunction

    // Rounds within a group count down in rotation-table index: 3,2,1,0 or 7,6,5,4.
    always_comb begin
        dm8 = {odd_reg, 2'b11} - {1'b0, cnt_reg};
        round_data = data_reg;
        for (int i = 0; i < STAGES; i++) begin
            round_data = inv_round(round_data, dm8 - 3'(i));
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        odd_next       = odd_reg;
        data_next      = data_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            IDLE: begin
                if (bus.inValid) begin
                    data_next  = bus.inData;
                    odd_next   = bus.groupOdd;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                data_next = round_data;
                if (cnt_reg == LAST_CNT) begin
                    state_next     = DONE;
                    out_valid_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 2'(STAGES);
                end
            end
            DONE: begin
                if (bus.outReady) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            odd_reg       <= 1'b0;
            data_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            odd_reg       <= odd_next;
            data_reg      <= data_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign bus.inReady  = (state_reg == IDLE);
    assign bus.outValid = out_valid_reg;
    assign bus.outData  = data_reg;
endmodule
